oc_monitor: RTL and testbench

//  Upstream stage of the turn/drive PWM blocks: generates their `oc` kill input.

---
 rtl/oc_monitor.sv | 152 +++++++++++++++
 tb/tb_oc_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/oc_monitor.sv
// rtl/oc_monitor.sv - overcurrent sense sync/debounce, trip cooldown, retry and lockout
// Optional: OC_AUTO_RETRY_EN enables cooldown auto-retry and quiet-time trip_count clear.
module oc_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COOLDOWN_CYCLES = 50000000,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 26
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sense_a,
  input  logic       sense_b,
  input  logic       clear_fault,
  output logic       oc,
  output logic       lockout,
  output logic [2:0] trip_count,
  output logic [1:0] fault_src
);

  typedef enum logic [1:0] {MONITOR, FAULT, LOCKOUT} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [2:0]       TC_MAX    = 3'(MAX_RETRIES);

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic                   synced_a, synced_b, s_hi;
  logic [CNT_W-1:0]       dcnt, dcnt_n, ccnt, ccnt_n;
  logic                   oc_n, lockout_n;
  logic [2:0]             tc_n;
  logic [1:0]             fs_n;
`ifdef OC_AUTO_RETRY_EN
  logic [CNT_W-1:0]       qcnt, qcnt_n;
`endif

  assign synced_a = sync_a[SYNC_STAGES-1];
  assign synced_b = sync_b[SYNC_STAGES-1];
  assign s_hi     = synced_a | synced_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= MONITOR;
      sync_a     <= '0;
      sync_b     <= '0;
      dcnt       <= '0;
      ccnt       <= '0;
      oc         <= 1'b0;
      lockout    <= 1'b0;
      trip_count <= '0;
      fault_src  <= '0;
`ifdef OC_AUTO_RETRY_EN
      qcnt       <= '0;
`endif
    end else begin
      state      <= state_n;
      sync_a     <= {sync_a[SYNC_STAGES-2:0], sense_a};
      sync_b     <= {sync_b[SYNC_STAGES-2:0], sense_b};
      dcnt       <= dcnt_n;
      ccnt       <= ccnt_n;
      oc         <= oc_n;
      lockout    <= lockout_n;
      trip_count <= tc_n;
      fault_src  <= fs_n;
`ifdef OC_AUTO_RETRY_EN
      qcnt       <= qcnt_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    ccnt_n    = ccnt;
    oc_n      = oc;
    lockout_n = lockout;
    tc_n      = trip_count;
    fs_n      = fault_src;
`ifdef OC_AUTO_RETRY_EN
    qcnt_n    = qcnt;
`endif
    // Clear outranks cooldown expiry; it is ignored while monitoring.
    if (state != MONITOR && clear_fault) begin
      state_n   = MONITOR;
      oc_n      = 1'b0;
      lockout_n = 1'b0;
      tc_n      = '0;
      dcnt_n    = '0;
      ccnt_n    = '0;
`ifdef OC_AUTO_RETRY_EN
      qcnt_n    = '0;
`endif
    end else begin
      case (state)
        MONITOR: begin
          if (s_hi) begin
`ifdef OC_AUTO_RETRY_EN
            qcnt_n = '0;
`endif
            if (dcnt == DEB_LAST) begin
              oc_n   = 1'b1;
              fs_n   = {synced_b, synced_a};
              tc_n   = (trip_count >= TC_MAX) ? TC_MAX : trip_count + 3'd1;
              dcnt_n = '0;
              ccnt_n = '0;
`ifdef OC_AUTO_RETRY_EN
              state_n = FAULT;
`else
              state_n   = LOCKOUT;
              lockout_n = 1'b1;
`endif
            end else begin
              dcnt_n = dcnt + CNT_W'(1);
            end
          end else begin
            dcnt_n = '0;
`ifdef OC_AUTO_RETRY_EN
            if (qcnt == COOL_LAST) begin
              tc_n   = '0;
              qcnt_n = '0;
            end else begin
              qcnt_n = qcnt + CNT_W'(1);
            end
`endif
          end
        end
        FAULT: begin
          if (ccnt == COOL_LAST) begin
            ccnt_n = '0;
            if (trip_count == TC_MAX) begin
              state_n   = LOCKOUT;
              lockout_n = 1'b1;
            end else begin
              state_n = MONITOR;
              oc_n    = 1'b0;
              dcnt_n  = '0;
            end
          end else begin
            ccnt_n = ccnt + CNT_W'(1);
          end
        end
        LOCKOUT: begin
          oc_n      = 1'b1;
          lockout_n = 1'b1;
        end
        default: state_n = MONITOR;
      endcase
    end
  end

endmodule

// File: tb/tb_oc_monitor.sv
// tb/tb_oc_monitor.sv - directed bench for oc_monitor (small debounce/cooldown parameters)
module tb_oc_monitor;

  logic       clock;
  logic       reset_n;
  logic       sense_a;
  logic       sense_b;
  logic       clear_fault;
  logic       oc;
  logic       lockout;
  logic [2:0] trip_count;
  logic [1:0] fault_src;

  int n_cmp = 0;
  int n_err = 0;

  oc_monitor #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(10),
    .MAX_RETRIES    (3),
    .CNT_W          (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sense_a    (sense_a),
    .sense_b    (sense_b),
    .clear_fault(clear_fault),
    .oc         (oc),
    .lockout    (lockout),
    .trip_count (trip_count),
    .fault_src  (fault_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    sense_a     = 1'b0;
    sense_b     = 1'b0;
    clear_fault = 1'b0;
    tick(2);
    chk("rst_oc",      8'(oc),         8'd0);
    chk("rst_lockout", 8'(lockout),    8'd0);
    chk("rst_tc",      8'(trip_count), 8'd0);
    chk("rst_fs",      8'(fault_src),  8'd0);
    reset_n = 1'b1;
    tick(1);

    // Three-cycle glitch must not trip.
    sense_a = 1'b1;
    tick(3);
    sense_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_oc", 8'(oc), 8'd0);
    end
    chk("glitch_tc", 8'(trip_count), 8'd0);

    // Sustained sense_a trips on edge 6 (2 sync + 4 debounce).
    sense_a = 1'b1;
    tick(5);
    chk("pre_trip_oc", 8'(oc), 8'd0);
    tick(1);
    chk("trip_oc", 8'(oc),         8'd1);
    chk("trip_fs", 8'(fault_src),  8'd1);
    chk("trip_tc", 8'(trip_count), 8'd1);
`ifdef OC_AUTO_RETRY_EN
    chk("trip_lockout", 8'(lockout), 8'd0);
    sense_a = 1'b0;
    tick(9);
    chk("cool_oc_held", 8'(oc), 8'd1);
    tick(1);
    chk("cool_oc_release", 8'(oc),         8'd0);
    chk("cool_lockout",    8'(lockout),    8'd0);
    chk("cool_tc_kept",    8'(trip_count), 8'd1);
    tick(9);
    chk("quiet_tc_pre", 8'(trip_count), 8'd1);
    tick(1);
    chk("quiet_tc_clr", 8'(trip_count), 8'd0);

    // Sustained sense_b: trips at 6, 20, 34; lockout after third cooldown at 44.
    sense_b = 1'b1;
    tick(6);
    chk("b1_oc", 8'(oc),         8'd1);
    chk("b1_tc", 8'(trip_count), 8'd1);
    chk("b1_fs", 8'(fault_src),  8'd2);
    tick(10);
    chk("b1_release", 8'(oc), 8'd0);
    tick(4);
    chk("b2_oc", 8'(oc),         8'd1);
    chk("b2_tc", 8'(trip_count), 8'd2);
    tick(14);
    chk("b3_tc", 8'(trip_count), 8'd3);
    tick(9);
    chk("b3_pre_lock", 8'(lockout), 8'd0);
    chk("b3_pre_oc",   8'(oc),      8'd1);
    tick(1);
    chk("lock_lockout", 8'(lockout),    8'd1);
    chk("lock_oc",      8'(oc),         8'd1);
    chk("lock_tc",      8'(trip_count), 8'd3);
    sense_b = 1'b0;
    tick(5);
    chk("lock_hold_lockout", 8'(lockout), 8'd1);
    chk("lock_hold_oc",      8'(oc),      8'd1);
    pulse_clear();
    chk("clr_oc",      8'(oc),         8'd0);
    chk("clr_lockout", 8'(lockout),    8'd0);
    chk("clr_tc",      8'(trip_count), 8'd0);
    chk("clr_fs_kept", 8'(fault_src),  8'd2);

    // Clear coinciding with cooldown expiry: clear wins, so trip_count is zeroed.
    sense_a = 1'b1;
    tick(6);
    chk("ce_trip_tc", 8'(trip_count), 8'd1);
    sense_a = 1'b0;
    tick(9);
    pulse_clear();
    chk("ce_oc",      8'(oc),         8'd0);
    chk("ce_tc",      8'(trip_count), 8'd0);
    chk("ce_lockout", 8'(lockout),    8'd0);
`else
    chk("trip_lockout", 8'(lockout), 8'd1);
    sense_a = 1'b0;
    tick(12);
    chk("noretry_oc",      8'(oc),      8'd1);
    chk("noretry_lockout", 8'(lockout), 8'd1);
    pulse_clear();
    chk("clr_oc",      8'(oc),         8'd0);
    chk("clr_lockout", 8'(lockout),    8'd0);
    chk("clr_tc",      8'(trip_count), 8'd0);
    chk("clr_fs_kept", 8'(fault_src),  8'd1);

    sense_b = 1'b1;
    tick(5);
    chk("b_pre_lockout", 8'(lockout), 8'd0);
    tick(1);
    chk("b_lockout", 8'(lockout),    8'd1);
    chk("b_oc",      8'(oc),         8'd1);
    chk("b_fs",      8'(fault_src),  8'd2);
    chk("b_tc",      8'(trip_count), 8'd1);
    sense_b = 1'b0;
    tick(3);
    pulse_clear();
    chk("b_clr_lockout", 8'(lockout),    8'd0);
    chk("b_clr_tc",      8'(trip_count), 8'd0);
`endif

    // Trip beats a concurrent clear in MONITOR, then async reset mid-fault.
    tick(3);
    sense_a     = 1'b1;
    clear_fault = 1'b1;
    tick(6);
    chk("trip_wins_oc", 8'(oc), 8'd1);
    clear_fault = 1'b0;
    tick(3);
    chk("fault_oc", 8'(oc), 8'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_oc",      8'(oc),         8'd0);
    chk("async_rst_lockout", 8'(lockout),    8'd0);
    chk("async_rst_tc",      8'(trip_count), 8'd0);
    chk("async_rst_fs",      8'(fault_src),  8'd0);
    sense_a = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("post_rst_oc",      8'(oc),         8'd0);
    chk("post_rst_lockout", 8'(lockout),    8'd0);
    chk("post_rst_tc",      8'(trip_count), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
